// File: rtl/ctrl_pipe_hazard_pkg.sv
// Shared types for the control pipeline: control word, ID/EX stage record,
// forwarding select encodings and the forwarding priority helper.
package ctrl_pipe_hazard_pkg;

  localparam int REG_AW  = 5;
  localparam int ALUOP_W = 2;

  typedef struct packed {
    logic               alusrc;
    logic               memtoreg;
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic [ALUOP_W-1:0] aluop;
    logic               branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // ID/EX stage contents; an all-zero record is a bubble
  typedef struct packed {
    ctrl_t             ctrl;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } id_ex_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // Younger producer (EX/MEM) wins; x0 is hardwired zero and never forwards
  function automatic logic [1:0] fwd_sel(input logic              mem_we,
                                         input logic [REG_AW-1:0] mem_rd,
                                         input logic              wb_we,
                                         input logic [REG_AW-1:0] wb_rd,
                                         input logic [REG_AW-1:0] rs);
    if (mem_we && mem_rd != '0 && mem_rd == rs)   return FWD_EXMEM;
    else if (wb_we && wb_rd != '0 && wb_rd == rs) return FWD_MEMWB;
    else                                          return FWD_RF;
  endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_if.sv
// Decoder/datapath facing bus of the control pipeline. The slave side is the
// pipeline block itself; the master side is whoever drives the ID stage.
interface ctrl_pipe_hazard_if;
  import ctrl_pipe_hazard_pkg::*;

  ctrl_t             id_ctrl;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              ex_branch_taken;

  ctrl_t             ex_ctrl;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  ctrl_t             mem_ctrl;
  logic [REG_AW-1:0] mem_rd;
  logic              wb_regwrite;
  logic              wb_memtoreg;
  logic [REG_AW-1:0] wb_rd;
  logic              pc_write_en;
  logic              if_id_write_en;
  logic              if_id_flush;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;

  modport master (
    output id_ctrl, id_valid, id_rs1, id_rs2, id_rd, ex_branch_taken,
    input  ex_ctrl, ex_rs1, ex_rs2, ex_rd, mem_ctrl, mem_rd,
           wb_regwrite, wb_memtoreg, wb_rd,
           pc_write_en, if_id_write_en, if_id_flush, fwd_a, fwd_b
  );

  modport slave (
    input  id_ctrl, id_valid, id_rs1, id_rs2, id_rd, ex_branch_taken,
    output ex_ctrl, ex_rs1, ex_rs2, ex_rd, mem_ctrl, mem_rd,
           wb_regwrite, wb_memtoreg, wb_rd,
           pc_write_en, if_id_write_en, if_id_flush, fwd_a, fwd_b
  );
endinterface

// File: rtl/ctrl_pipe_hazard_fwd_unit.sv
// EX-stage forwarding selects, one per ALU operand (0 = A/rs1, 1 = B/rs2).
module ctrl_pipe_hazard_fwd_unit
  import ctrl_pipe_hazard_pkg::*;
#(
  parameter int NUM_OPS = 2
) (
  input  logic                           mem_regwrite,
  input  logic [REG_AW-1:0]              mem_rd,
  input  logic                           wb_regwrite,
  input  logic [REG_AW-1:0]              wb_rd,
  input  logic [NUM_OPS-1:0][REG_AW-1:0] ex_rs,
  output logic [NUM_OPS-1:0][1:0]        fwd
);

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    // Per-operand source select, EX/MEM before MEM/WB
    always_comb fwd[g] = fwd_sel(mem_regwrite, mem_rd, wb_regwrite, wb_rd, ex_rs[g]);
  end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// Control-word pipeline ID/EX -> EX/MEM -> MEM/WB with load-use stall,
// taken-branch flush and EX-stage forwarding selects.
module ctrl_pipe_hazard
  import ctrl_pipe_hazard_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  ctrl_pipe_hazard_if.slave bus
);

  id_ex_t            ex_q;
  ctrl_t             mem_ctrl_q;
  logic [REG_AW-1:0] mem_rd_q;
  logic              wb_we_q;
  logic              wb_m2r_q;
  logic [REG_AW-1:0] wb_rd_q;

  logic   stall, flush, hold, bubble;
  id_ex_t id_rec;

  // Load-use detect; a taken branch overrides it since the ID instruction dies
  always_comb begin
    stall  = ex_q.ctrl.memread && ex_q.rd != '0 && bus.id_valid &&
             (ex_q.rd == bus.id_rs1 || ex_q.rd == bus.id_rs2);
    flush  = bus.ex_branch_taken;
    hold   = stall && !flush;
    bubble = stall || flush || !bus.id_valid;
    id_rec = '{ctrl: bus.id_ctrl, rs1: bus.id_rs1, rs2: bus.id_rs2, rd: bus.id_rd};
  end

  // Stage registers; EX/MEM and MEM/WB always advance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q       <= '0;
      mem_ctrl_q <= CTRL_NOP;
      mem_rd_q   <= '0;
      wb_we_q    <= 1'b0;
      wb_m2r_q   <= 1'b0;
      wb_rd_q    <= '0;
    end else begin
      ex_q       <= bubble ? id_ex_t'('0) : id_rec;
      mem_ctrl_q <= ex_q.ctrl;
      mem_rd_q   <= ex_q.rd;
      wb_we_q    <= mem_ctrl_q.regwrite;
      wb_m2r_q   <= mem_ctrl_q.memtoreg;
      wb_rd_q    <= mem_rd_q;
    end
  end

  logic [1:0][REG_AW-1:0] ex_rs;
  logic [1:0][1:0]        fwd;

  // Operand order matches fwd_unit: [0] = A/rs1, [1] = B/rs2
  always_comb ex_rs = {ex_q.rs2, ex_q.rs1};

  ctrl_pipe_hazard_fwd_unit #(.NUM_OPS(2)) fwd_unit (
    .mem_regwrite (mem_ctrl_q.regwrite),
    .mem_rd       (mem_rd_q),
    .wb_regwrite  (wb_we_q),
    .wb_rd        (wb_rd_q),
    .ex_rs        (ex_rs),
    .fwd          (fwd)
  );

  // Output mapping
  always_comb begin
    bus.ex_ctrl        = ex_q.ctrl;
    bus.ex_rs1         = ex_q.rs1;
    bus.ex_rs2         = ex_q.rs2;
    bus.ex_rd          = ex_q.rd;
    bus.mem_ctrl       = mem_ctrl_q;
    bus.mem_rd         = mem_rd_q;
    bus.wb_regwrite    = wb_we_q;
    bus.wb_memtoreg    = wb_m2r_q;
    bus.wb_rd          = wb_rd_q;
    bus.pc_write_en    = !hold;
    bus.if_id_write_en = !hold;
    bus.if_id_flush    = flush;
    bus.fwd_a          = fwd[0];
    bus.fwd_b          = fwd[1];
  end

endmodule
